// File: rtl/multi_rate_timer.sv
// Multi-channel programmable tick generator: each channel raises a one-cycle Enable
// every P cycles (periodic) or once (one-shot), with glitch-free period updates.
module multi_rate_timer #(
    parameter int unsigned WIDTH          = 24,
    parameter int unsigned NCH            = 4,
    parameter int unsigned DEFAULT_PERIOD = 12_500_000,
    localparam int unsigned CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             WrEn,
    input  logic [CHW-1:0]   WrCh,
    input  logic [WIDTH-1:0] WrPeriod,
    input  logic [NCH-1:0]   Start,
    input  logic [NCH-1:0]   Stop,
    input  logic [NCH-1:0]   OneShot,
    output logic [NCH-1:0]   Enable,
    output logic [NCH-1:0]   Busy,
    output logic             WrErr
);

    // state   | meaning
    // ST_IDLE | channel halted, writes go straight to the active period
    // ST_RUN  | counting; writes are held as pending until terminal count or Stop
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CHW:0]     NCH_LIM   = (CHW+1)'(NCH);
    localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(DEFAULT_PERIOD);

    state_t           state_q    [NCH];
    state_t           state_d    [NCH];
    logic [WIDTH-1:0] count_q    [NCH];
    logic [WIDTH-1:0] count_d    [NCH];
    logic [WIDTH-1:0] period_q   [NCH];
    logic [WIDTH-1:0] period_d   [NCH];
    logic [WIDTH-1:0] pend_q     [NCH];
    logic [WIDTH-1:0] pend_d     [NCH];
    logic [NCH-1:0]   pend_vld_q;
    logic [NCH-1:0]   pend_vld_d;
    logic [NCH-1:0]   oneshot_q;
    logic [NCH-1:0]   oneshot_d;
    logic [NCH-1:0]   enable_q;
    logic [NCH-1:0]   enable_d;
    logic [NCH-1:0]   busy_q;
    logic [NCH-1:0]   busy_d;
    logic             wr_err_q;
    logic             wr_err_d;

    logic             wr_bad;
    logic [NCH-1:0]   wr_hit;
    logic [NCH-1:0]   term;

    always_comb begin
        wr_bad   = WrEn && ((WrPeriod == '0) || ({1'b0, WrCh} >= NCH_LIM));
        wr_err_d = wr_bad;
        wr_hit   = '0;
        term     = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = WrEn && !wr_bad && (WrCh == CHW'(i));
            term[i]   = (count_q[i] == (period_q[i] - WIDTH'(1)));
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i]    = state_q[i];
            count_d[i]    = count_q[i];
            period_d[i]   = period_q[i];
            pend_d[i]     = pend_q[i];
            pend_vld_d[i] = pend_vld_q[i];
            oneshot_d[i]  = oneshot_q[i];
            enable_d[i]   = 1'b0;

            case (state_q[i])
                ST_IDLE: begin
                    if (wr_hit[i]) begin
                        period_d[i] = WrPeriod;
                    end
                    if (Start[i] && !Stop[i]) begin
                        state_d[i]   = ST_RUN;
                        count_d[i]   = '0;
                        oneshot_d[i] = OneShot[i];
                    end
                end
                ST_RUN: begin
                    if (Stop[i]) begin
                        state_d[i]    = ST_IDLE;
                        count_d[i]    = '0;
                        pend_vld_d[i] = 1'b0;
                        if (wr_hit[i]) begin
                            period_d[i] = WrPeriod;
                        end else if (pend_vld_q[i]) begin
                            period_d[i] = pend_q[i];
                        end
                    end else if (Start[i]) begin
                        // Retrigger restarts the period but keeps any pending value queued.
                        count_d[i]   = '0;
                        oneshot_d[i] = OneShot[i];
                        if (wr_hit[i]) begin
                            pend_d[i]     = WrPeriod;
                            pend_vld_d[i] = 1'b1;
                        end
                    end else if (term[i]) begin
                        count_d[i]    = '0;
                        enable_d[i]   = 1'b1;
                        pend_vld_d[i] = 1'b0;
                        if (oneshot_q[i]) begin
                            state_d[i] = ST_IDLE;
                        end
                        if (wr_hit[i]) begin
                            period_d[i] = WrPeriod;
                        end else if (pend_vld_q[i]) begin
                            period_d[i] = pend_q[i];
                        end
                    end else begin
                        count_d[i] = count_q[i] + WIDTH'(1);
                        if (wr_hit[i]) begin
                            pend_d[i]     = WrPeriod;
                            pend_vld_d[i] = 1'b1;
                        end
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase

            busy_d[i] = (state_d[i] == ST_RUN);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= ST_IDLE;
                count_q[i]  <= '0;
                period_q[i] <= PERIOD_RST;
                pend_q[i]   <= '0;
            end
            pend_vld_q <= '0;
            oneshot_q  <= '0;
            enable_q   <= '0;
            busy_q     <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                count_q[i]  <= count_d[i];
                period_q[i] <= period_d[i];
                pend_q[i]   <= pend_d[i];
            end
            pend_vld_q <= pend_vld_d;
            oneshot_q  <= oneshot_d;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign Enable = enable_q;
    assign Busy   = busy_q;
    assign WrErr  = wr_err_q;

endmodule

// File: tb/tb_multi_rate_timer.sv
// Directed self-checking bench for multi_rate_timer with 3 channels, 8-bit periods, default period 5.
module tb_multi_rate_timer;

    localparam int WIDTH = 8;
    localparam int NCH   = 3;
    localparam int CHW   = 2;

    logic             Clk;
    logic             Reset;
    logic             WrEn;
    logic [CHW-1:0]   WrCh;
    logic [WIDTH-1:0] WrPeriod;
    logic [NCH-1:0]   Start;
    logic [NCH-1:0]   Stop;
    logic [NCH-1:0]   OneShot;
    logic [NCH-1:0]   Enable;
    logic [NCH-1:0]   Busy;
    logic             WrErr;

    int n_checks = 0;
    int n_errors = 0;

    multi_rate_timer #(
        .WIDTH(WIDTH),
        .NCH(NCH),
        .DEFAULT_PERIOD(5)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .WrEn(WrEn),
        .WrCh(WrCh),
        .WrPeriod(WrPeriod),
        .Start(Start),
        .Stop(Stop),
        .OneShot(OneShot),
        .Enable(Enable),
        .Busy(Busy),
        .WrErr(WrErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach summary, elapsed=%0t required<200000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_period(input int ch, input int p);
        WrEn = 1'b1; WrCh = CHW'(ch); WrPeriod = WIDTH'(p);
        tick();
        WrEn = 1'b0;
    endtask

    task automatic stop_ch(input int ch);
        Stop[ch] = 1'b1;
        tick();
        Stop = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if ({Enable, Busy, WrErr} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got En=%b Busy=%b WrErr=%b, want all 0", Enable, Busy, WrErr);
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_periodic();
        logic [NCH-1:0] exp_en;
        Start[0] = 1'b1; OneShot[0] = 1'b0;
        tick();
        Start = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_en = (k % 5 == 0) ? 3'b001 : 3'b000;
            n_checks++;
            if (Enable !== exp_en || Busy !== 3'b001) begin
                n_errors++;
                $display("FAIL periodic k=%0d: got En=%b Busy=%b, want En=%b Busy=001", k, Enable, Busy, exp_en);
            end
        end
        stop_ch(0);
        n_checks++;
        if (Enable !== 3'b000 || Busy !== 3'b000) begin
            n_errors++;
            $display("FAIL periodic_stop: got En=%b Busy=%b, want 000/000", Enable, Busy);
        end
    endtask

    task automatic test_oneshot();
        logic [NCH-1:0] exp_en;
        logic [NCH-1:0] exp_busy;
        write_period(1, 3);
        n_checks++;
        if (WrErr !== 1'b0) begin
            n_errors++;
            $display("FAIL oneshot_write_err: got WrErr=%b, want 0", WrErr);
        end
        Start[1] = 1'b1; OneShot[1] = 1'b1;
        tick();
        Start = '0; OneShot = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_en   = (k == 3) ? 3'b010 : 3'b000;
            exp_busy = (k < 3) ? 3'b010 : 3'b000;
            n_checks++;
            if (Enable !== exp_en || Busy !== exp_busy) begin
                n_errors++;
                $display("FAIL oneshot k=%0d: got En=%b Busy=%b, want En=%b Busy=%b", k, Enable, Busy, exp_en, exp_busy);
            end
        end
    endtask

    task automatic test_period_write();
        logic [NCH-1:0] exp_en;
        write_period(0, 4);
        Start[0] = 1'b1; OneShot[0] = 1'b0;
        tick();
        Start = '0;
        for (int k = 1; k <= 23; k++) begin
            WrEn     = (k == 2 || k == 18);
            WrCh     = 2'd0;
            WrPeriod = (k == 2) ? 8'd7 : 8'd2;
            tick();
            WrEn = 1'b0;
            exp_en = (k == 4 || k == 11 || k == 18 || k == 20 || k == 22) ? 3'b001 : 3'b000;
            n_checks++;
            if (Enable !== exp_en || Busy !== 3'b001) begin
                n_errors++;
                $display("FAIL period_write k=%0d: got En=%b Busy=%b, want En=%b Busy=001", k, Enable, Busy, exp_en);
            end
        end
        stop_ch(0);
    endtask

    task automatic test_start_stop();
        Start[2] = 1'b1; Stop[2] = 1'b1;
        tick();
        Start = '0; Stop = '0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) tick();
            n_checks++;
            if (Enable !== 3'b000 || Busy !== 3'b000) begin
                n_errors++;
                $display("FAIL start_stop_same k=%0d: got En=%b Busy=%b, want 000/000", k, Enable, Busy);
            end
        end
        Start[2] = 1'b1; OneShot[2] = 1'b0;
        tick();
        Start = '0;
        for (int k = 1; k <= 8; k++) begin
            Stop[2] = (k == 5);
            tick();
            Stop = '0;
            n_checks++;
            if (Enable !== 3'b000 || Busy !== ((k < 5) ? 3'b100 : 3'b000)) begin
                n_errors++;
                $display("FAIL stop_on_terminal k=%0d: got En=%b Busy=%b, want En=000 Busy=%b", k, Enable, Busy, (k < 5) ? 3'b100 : 3'b000);
            end
        end
    endtask

    task automatic test_retrigger();
        logic [NCH-1:0] exp_en;
        Start[2] = 1'b1; OneShot[2] = 1'b0;
        tick();
        Start = '0;
        for (int k = 1; k <= 9; k++) begin
            Start[2] = (k == 3);
            tick();
            Start = '0;
            exp_en = (k == 8) ? 3'b100 : 3'b000;
            n_checks++;
            if (Enable !== exp_en || Busy !== 3'b100) begin
                n_errors++;
                $display("FAIL retrigger k=%0d: got En=%b Busy=%b, want En=%b Busy=100", k, Enable, Busy, exp_en);
            end
        end
        stop_ch(2);
    endtask

    task automatic test_wr_err();
        logic [NCH-1:0] exp_en;
        write_period(1, 0);
        n_checks++;
        if (WrErr !== 1'b1) begin
            n_errors++;
            $display("FAIL wrerr_zero: got WrErr=%b, want 1", WrErr);
        end
        tick();
        n_checks++;
        if (WrErr !== 1'b0) begin
            n_errors++;
            $display("FAIL wrerr_zero_width: got WrErr=%b, want 0", WrErr);
        end
        write_period(NCH, 9);
        n_checks++;
        if (WrErr !== 1'b1) begin
            n_errors++;
            $display("FAIL wrerr_badch: got WrErr=%b, want 1", WrErr);
        end
        tick();
        n_checks++;
        if (WrErr !== 1'b0) begin
            n_errors++;
            $display("FAIL wrerr_badch_width: got WrErr=%b, want 0", WrErr);
        end
        Start[1] = 1'b1; OneShot[1] = 1'b1;
        tick();
        Start = '0; OneShot = '0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_en = (k == 3) ? 3'b010 : 3'b000;
            n_checks++;
            if (Enable !== exp_en) begin
                n_errors++;
                $display("FAIL wrerr_period_kept k=%0d: got En=%b, want %b", k, Enable, exp_en);
            end
        end
        write_period(1, 1);
        Start[1] = 1'b1; OneShot[1] = 1'b0;
        tick();
        Start = '0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if (Enable !== 3'b010 || Busy !== 3'b010) begin
                n_errors++;
                $display("FAIL period_one k=%0d: got En=%b Busy=%b, want 010/010", k, Enable, Busy);
            end
        end
        stop_ch(1);
        n_checks++;
        if (Enable !== 3'b000 || Busy !== 3'b000) begin
            n_errors++;
            $display("FAIL period_one_stop: got En=%b Busy=%b, want 000/000", Enable, Busy);
        end
    endtask

    task automatic test_reset_async();
        logic [NCH-1:0] exp_en;
        Start = 3'b111; OneShot = 3'b000;
        tick();
        Start = '0;
        tick();
        tick();
        #3;
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({Enable, Busy, WrErr} !== 7'b0) begin
            n_errors++;
            $display("FAIL async_reset: got En=%b Busy=%b WrErr=%b, want all 0", Enable, Busy, WrErr);
        end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (Enable !== 3'b000 || Busy !== 3'b000) begin
                n_errors++;
                $display("FAIL post_reset_idle k=%0d: got En=%b Busy=%b, want 000/000", k, Enable, Busy);
            end
        end
        Start[0] = 1'b1;
        tick();
        Start = '0;
        n_checks++;
        if (Busy !== 3'b001) begin
            n_errors++;
            $display("FAIL post_reset_start: got Busy=%b, want 001", Busy);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_en = (k == 5) ? 3'b001 : 3'b000;
            n_checks++;
            if (Enable !== exp_en) begin
                n_errors++;
                $display("FAIL post_reset_period k=%0d: got En=%b, want %b", k, Enable, exp_en);
            end
        end
        stop_ch(0);
    endtask

    initial begin
        Reset = 1'b1;
        WrEn = 1'b0; WrCh = '0; WrPeriod = '0;
        Start = '0; Stop = '0; OneShot = '0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_period_write();
        test_start_stop();
        test_retrigger();
        test_wr_err();
        test_reset_async();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
